// File: rtl/l1c_refill_arbiter.sv
// Round-robin arbiter sharing one burst-read port between the L1 I-cache (req 0) and D-cache (req 1) refills.
// Optional watchdog abort is compiled in with `define REFILL_TIMEOUT_EN.
module l1c_refill_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BEATS   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        req_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rvalid_o,
    output logic              rlast_o,
    output logic [1:0]        wait_o,
    output logic [1:0]        gnt_o,
    output logic [1:0]        err_o,
    output logic              arvalid_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [3:0]        arlen_o,
    input  logic              arready_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rlast_i,
    output logic              rready_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [3:0]        BURST_LEN  = 4'(BEATS - 1);

    logic [1:0]        state;
    logic [1:0]        gnt_q;
    logic              rr;
    logic [CNT_W-1:0]  cnt;
    logic              dropped;
    logic [ADDR_W-1:0] araddr_q;
    logic [3:0]        arlen_q;

    logic              g;
    logic              in_data;
    logic              beat;
    logic              final_beat;
    logic              win;
    logic [ADDR_W-1:0] win_addr;
    logic              timeout;
    logic              done;
    logic [1:0]        done_mask;

    assign g          = gnt_q[1];
    assign in_data    = (state == S_DATA);
    assign beat       = in_data & rvalid_i;
    assign final_beat = beat & ((cnt == LAST_CNT) | rlast_i);
    assign win        = req_i[rr] ? rr : ~rr;
    assign win_addr   = win ? addr1_i : addr0_i;

`ifdef REFILL_TIMEOUT_EN
    logic [7:0] wdog;

    // Watchdog restarts whenever the port shows life; it saturates rather than wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog <= '0;
        end else if (state == S_IDLE || beat) begin
            wdog <= '0;
        end else if (wdog != 8'hFF) begin
            wdog <= wdog + 8'd1;
        end
    end

    assign timeout = (state != S_IDLE) && !beat && (wdog == 8'(TIMEOUT));
    assign err_o   = timeout ? gnt_q : 2'b00;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign timeout        = 1'b0;
    assign err_o          = 2'b00;
`endif

    assign done      = final_beat | timeout;
    assign done_mask = done ? gnt_q : 2'b00;

    // Beats are always drained once the burst has started; delivery is masked if the owner gave up.
    assign rvalid_o  = (beat && req_i[g] && !dropped) ? gnt_q : 2'b00;
    assign rdata_o   = beat ? rdata_i : '0;
    assign rlast_o   = beat & rlast_i;
    assign rready_o  = in_data;
    assign arvalid_o = (state == S_ADDR);
    assign wait_o    = req_i & ~done_mask;
    assign gnt_o     = gnt_q;
    assign araddr_o  = araddr_q;
    assign arlen_o   = arlen_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            gnt_q    <= 2'b00;
            rr       <= 1'b0;
            cnt      <= '0;
            dropped  <= 1'b0;
            araddr_q <= '0;
            arlen_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    dropped <= 1'b0;
                    if (|req_i) begin
                        gnt_q    <= win ? 2'b10 : 2'b01;
                        araddr_q <= win_addr & ALIGN_MASK;
                        arlen_q  <= BURST_LEN;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!req_i[g]) dropped <= 1'b1;
                    if (timeout) begin
                        state <= S_IDLE;
                        gnt_q <= 2'b00;
                        rr    <= ~g;
                    end else if (arready_i) begin
                        state <= S_DATA;
                        cnt   <= '0;
                        rr    <= ~g;
                    end
                end
                S_DATA: begin
                    if (!req_i[g]) dropped <= 1'b1;
                    if (done) begin
                        state <= S_IDLE;
                        gnt_q <= 2'b00;
                    end else if (beat) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l1c_refill_arbiter.sv
// Self-checking bench for l1c_refill_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_l1c_refill_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic [1:0]        req_i;
    logic [ADDR_W-1:0] addr0_i, addr1_i;
    logic [DATA_W-1:0] rdata_o;
    logic [1:0]        rvalid_o, wait_o, gnt_o, err_o;
    logic              rlast_o, arvalid_o, rready_o;
    logic [ADDR_W-1:0] araddr_o;
    logic [3:0]        arlen_o;
    logic              arready_i, rvalid_i, rlast_i;
    logic [DATA_W-1:0] rdata_i;

    always #5 clk = ~clk;

    l1c_refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .rstn(rstn), .req_i(req_i), .addr0_i(addr0_i), .addr1_i(addr1_i),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rlast_o(rlast_o), .wait_o(wait_o),
        .gnt_o(gnt_o), .err_o(err_o), .arvalid_o(arvalid_o), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arready_i(arready_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
        .rlast_i(rlast_i), .rready_o(rready_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port, whether the address was accepted, beats delivered.
    int          m_owner;
    bit          m_addr_done;
    int          m_beats;
    int          m_rr;
    bit          m_dropped;
    logic [31:0] m_addr;
    int          m_bursts;
    int          m_fin_owner;

    // Slave/requester behaviour knobs and observations.
    int   ar_pct, r_pct, early_pct;
    bit   rv_anytime, data_seq, auto_drop;
    int   beats_seen[2];
    int   gnt_log[$];
    logic [1:0] prev_gnt;

    task automatic model_reset();
        m_owner = -1; m_addr_done = 0; m_beats = 0; m_rr = 0; m_dropped = 0;
        m_addr = '0; m_bursts = 0; m_fin_owner = -1;
        beats_seen[0] = 0; beats_seen[1] = 0;
        gnt_log.delete();
        prev_gnt = 2'b00;
    endtask

    task automatic model_step();
        m_fin_owner = -1;
        if (!rstn) begin
            model_reset();
        end else if (m_owner < 0) begin
            if (req_i != 2'b00) begin
                m_owner     = req_i[m_rr] ? m_rr : 1 - m_rr;
                m_addr      = (m_owner == 1 ? addr1_i : addr0_i) & ~32'hF;
                m_addr_done = 0;
                m_dropped   = 0;
            end
        end else begin
            if (!req_i[m_owner]) m_dropped = 1;
            if (!m_addr_done) begin
                if (arready_i) begin
                    m_addr_done = 1;
                    m_beats     = 0;
                    m_rr        = 1 - m_owner;
                end
            end else if (rvalid_i) begin
                if (m_beats == BEATS - 1 || rlast_i) begin
                    m_fin_owner = m_owner;
                    m_owner     = -1;
                    m_bursts++;
                end else begin
                    m_beats++;
                end
            end
        end
    endtask

    task automatic drive_slave();
        arready_i = ($urandom_range(99) < ar_pct);
        if ((m_owner >= 0 && m_addr_done) || rv_anytime)
            rvalid_i = ($urandom_range(99) < r_pct);
        else
            rvalid_i = 1'b0;
        rdata_i = data_seq ? 32'hA0 + 32'(m_beats) : $urandom;
        rlast_i = (m_beats == BEATS - 1) || ($urandom_range(99) < early_pct);
    endtask

    task automatic check_outputs();
        logic [1:0] exp_gnt, exp_rv, exp_wait;
        bit beat, fin;
        exp_gnt  = (m_owner >= 0) ? 2'(2'b01 << m_owner) : 2'b00;
        beat     = (m_owner >= 0) && m_addr_done && rvalid_i;
        fin      = beat && (m_beats == BEATS - 1 || rlast_i);
        exp_rv   = (beat && req_i[m_owner] && !m_dropped) ? exp_gnt : 2'b00;
        exp_wait = req_i & ~(fin ? exp_gnt : 2'b00);
        check("gnt", gnt_o, exp_gnt);
        check("arvalid", arvalid_o, (m_owner >= 0 && !m_addr_done));
        check("rready", rready_o, (m_owner >= 0 && m_addr_done));
        check("rvalid", rvalid_o, exp_rv);
        check("wait", wait_o, exp_wait);
        check("err", err_o, 2'b00);
        if (m_owner >= 0) begin
            check("araddr", araddr_o, m_addr);
            check("arlen", arlen_o, BEATS - 1);
        end
        if (beat) begin
            check("rdata", rdata_o, rdata_i);
            check("rlast", rlast_o, rlast_i);
        end
        for (int k = 0; k < 2; k++) if (rvalid_o[k]) beats_seen[k]++;
        if (gnt_o != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(int'(gnt_o));
        prev_gnt = gnt_o;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (auto_drop && m_fin_owner >= 0) req_i[m_fin_owner] = 1'b0;
        drive_slave();
        #3;
        check_outputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, gnt_o, 2'b00);
        check({tag, "_arvalid"}, arvalid_o, 1'b0);
        check({tag, "_araddr"}, araddr_o, '0);
        check({tag, "_arlen"}, arlen_o, 4'd0);
        check({tag, "_rready"}, rready_o, 1'b0);
        check({tag, "_rvalid"}, rvalid_o, 2'b00);
        check({tag, "_rlast"}, rlast_o, 1'b0);
        check({tag, "_rdata"}, rdata_o, '0);
        check({tag, "_err"}, err_o, 2'b00);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        req_i = 2'b00; arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = '0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        #2;
        ar_pct = 100; r_pct = 100; early_pct = 0;
        rv_anytime = 0; data_seq = 0; auto_drop = 1;
    endtask

    task automatic run_until_bursts(input string tag, input int n, input int bound);
        for (int i = 0; i < bound && m_bursts < n; i++) cycle();
        if (m_bursts < n) check({tag, "_bound"}, m_bursts, n);
    endtask

    initial begin
        addr0_i = '0; addr1_i = '0;
        do_reset("rst0");

        // 1: single I-cache refill with aligned address and beat data A0..A3.
        addr0_i = 32'h0000_1234; data_seq = 1; req_i = 2'b01;
        run_until_bursts("t1", 1, 40);
        req_i = 2'b00;
        repeat (2) cycle();
        check("t1_beats", beats_seen[0], 4);
        check("t1_araddr", araddr_o, 32'h0000_1230);

        // 2: simultaneous requests after reset: I-cache first, then D-cache.
        do_reset("rst2");
        addr0_i = 32'h0000_2008; addr1_i = 32'h8000_00FC; req_i = 2'b11;
        run_until_bursts("t2", 2, 60);
        check("t2_ngrants", gnt_log.size(), 2);
        if (gnt_log.size() >= 2) begin
            check("t2_first", gnt_log[0], 1);
            check("t2_second", gnt_log[1], 2);
        end
        check("t2_beats1", beats_seen[1], 4);

        // 3: continuous contention alternates the grant.
        do_reset("rst3");
        auto_drop = 0; req_i = 2'b11;
        run_until_bursts("t3", 4, 80);
        req_i = 2'b00;
        repeat (3) cycle();
        check("t3_ngrants", gnt_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check("t3_alt", gnt_log[i], (i % 2 == 0) ? 1 : 2);

        // 4: address stall then gappy data; address must stay stable under input changes.
        do_reset("rst4");
        addr0_i = 32'h0000_4444; ar_pct = 0; req_i = 2'b01;
        for (int i = 0; i < 10; i++) begin
            cycle();
            addr0_i = $urandom;
        end
        ar_pct = 100; r_pct = 40;
        run_until_bursts("t4", 1, 200);
        check("t4_beats", beats_seen[0], 4);

        // 5: D-cache drops its request after the first delivered beat.
        do_reset("rst5");
        req_i = 2'b10;
        for (int i = 0; i < 20 && beats_seen[1] < 1; i++) cycle();
        req_i[1] = 1'b0;
        run_until_bursts("t5", 1, 20);
        cycle();
        check("t5_beats", beats_seen[1], 1);
        check("t5_idle_gnt", gnt_o, 2'b00);

        // 6: asynchronous reset in the middle of a burst.
        do_reset("rst6");
        req_i = 2'b01; r_pct = 50;
        for (int i = 0; i < 40 && !(m_addr_done && m_beats >= 2 && m_owner >= 0); i++) cycle();
        check("t6_midburst", gnt_o, 2'b01);
        do_reset("rst_mid");

        // Randomized traffic with early rlast, drops, stalls and stray rvalid_i.
        ar_pct = 70; r_pct = 60; early_pct = 5; rv_anytime = 1; auto_drop = 1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (!req_i[k] && $urandom_range(7) == 0) req_i[k] = 1'b1;
                else if (req_i[k] && $urandom_range(63) == 0) req_i[k] = 1'b0;
            end
            if ($urandom_range(3) == 0) addr0_i = $urandom;
            if ($urandom_range(3) == 0) addr1_i = $urandom;
        end
        check("rand_progress", m_bursts > 50, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l1c_refill_arbiter.md
Name: l1c_refill_arbiter

Overview:
- Shares one burst-read memory port between the L1 instruction-cache refill path (requester 0) and the L1 data-cache refill path (requester 1).
- Sits between both L1 caches and the CPU wrapper's AXI read master.
- Grants one requester at a time with round-robin fairness, issues a single aligned burst of BEATS words, and routes each returned beat and its handshake to the granted cache.
- Guarantees that a burst, once started, is never split between requesters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, beat width.
- BEATS, 4, words per cache line; the burst length sent is BEATS-1.
- TIMEOUT, 255, cycles without a beat before abort (optional feature only).

Ports:
- clk in 1: single clock.
- rstn in 1: asynchronous active-low reset.
- req_i in 2: refill request per requester; bit0 = icache, bit1 = dcache.
- addr0_i in ADDR_W: refill address from requester 0.
- addr1_i in ADDR_W: refill address from requester 1.
- rdata_o out DATA_W: returned beat, broadcast to both requesters.
- rvalid_o out 2: beat valid, asserted only on the granted requester's bit.
- rlast_o out 1: final beat of the burst.
- wait_o out 2: per-requester busy.
- gnt_o out 2: one-hot current grant.
- err_o out 2: abort pulse per requester (optional feature only; tied 0 otherwise).
- arvalid_o out 1: read-address valid to the AXI master.
- araddr_o out ADDR_W: read address to the AXI master.
- arlen_o out 4: burst length to the AXI master.
- arready_i in 1: read-address ready from the AXI master.
- rvalid_i in 1: beat valid from the AXI master.
- rdata_i in DATA_W: beat data from the AXI master.
- rlast_i in 1: last-beat flag from the AXI master.
- rready_o out 1: beat ready to the AXI master.

Behaviour:
- Reset (async, rstn low):
  - State IDLE; gnt_o=0; arvalid_o=0; araddr_o=0; arlen_o=0; rready_o=0; rvalid_o=0; rlast_o=0; rdata_o=0; err_o=0.
  - Beat counter 0; round-robin pointer rr=0, meaning requester 0 has priority.
- State IDLE:
  - If no req_i bit is set, stay in IDLE.
  - Otherwise choose the winner: the requester named by rr if it is requesting, else the other one.
  - Register gnt_o one-hot, latch araddr_o = winner addr with the low log2(BEATS*DATA_W/8) bits cleared, set arlen_o = BEATS-1, then go to ADDR.
  - Latency from req_i to arvalid_o is 1 cycle.
- State ADDR:
  - arvalid_o=1; araddr_o and arlen_o are held stable until arready_i.
  - On arvalid_o & arready_i, go to DATA, clear the beat counter, and set rr = the non-granted requester.
- State DATA:
  - rready_o=1.
  - Each rvalid_i & rready_o is one beat. rdata_o = rdata_i combinationally, and rvalid_o[gnt] = rvalid_i.
  - The beat counter increments on each beat; rlast_o = rlast_i.
  - On the beat where counter==BEATS-1, or rlast_i, whichever comes first, go to IDLE and clear gnt_o.
  - If rlast_i arrives while counter != BEATS-1, the burst still ends.
- wait_o[k]:
  - =1 when req_i[k] is set and the block is not on the final beat for k.
  - =0 in the cycle the final beat for k is delivered.
  - =0 when req_i[k]=0.
- Simultaneous requests: both bits rising in the same cycle resolve by rr. Under continuous contention the loser is served next; no requester waits more than one burst.
- Request dropped mid-burst: the burst continues and beats are drained with rready_o=1, but rvalid_o is suppressed for the dropped requester. The grant is never switched mid-burst.
- A new request from the same requester in the cycle the burst completes is arbitrated in the following IDLE cycle, so there is 1 idle cycle between bursts.
- Address change while granted: ignored; the latched address is used.
- Reset mid-burst: immediate return to IDLE with all outputs at reset values. The downstream master is reset by the same rstn.

Optional Feature:
- Macro REFILL_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog clears on entering ADDR and on each beat, and increments every cycle in ADDR or DATA.
  - On reaching TIMEOUT it forces IDLE, clears gnt_o and arvalid_o, and pulses err_o[gnt] for 1 cycle.
  - It also deasserts wait_o for that requester in the same cycle; rr advances as if the burst had completed.
- When undefined: no watchdog; err_o is constant 0; the block waits indefinitely.

Test Plan:
1. Only req_i=01, addr0_i=0x0000_1234, arready_i=1 next cycle, 4 beats 0xA0..0xA3 → araddr_o=0x0000_1230, arlen_o=3; rvalid_o=01 for each beat; wait_o[0] falls on beat 4; gnt_o=00 after.
2. req_i=11 in the same cycle after reset → icache is granted first. After its 4 beats and 1 idle cycle, dcache is granted with araddr_o=addr1_i aligned, and rr=1→0 order is verified.
3. req_i=11 held for 4 back-to-back bursts → grants alternate 01,10,01,10.
4. arready_i held low 10 cycles, then rvalid_i with gaps → arvalid_o and araddr_o stay stable; the counter increments only on handshakes; exactly 4 beats are delivered.
5. req_i[1] drops after beat 1 → rready_o stays 1; beats 2-4 are consumed with rvalid_o=00; the block returns to IDLE.
6. With REFILL_TIMEOUT_EN and TIMEOUT=255: no rvalid_i after the address handshake → err_o pulses 01 at cycle 255; the block returns to IDLE. Also, rstn pulsed low mid-burst → all outputs return to 0 asynchronously.
